systolic_feed_controller: RTL
=============================

# systolic_feed_controller

Sequencer that streams weight/activation tiles from a row-organised SRAM buffer into the systolic data-setup skew stage. It issues buffer reads, applies each row to the skew stage with its enable, clears the skew registers before a job, and flushes them with zeros after each tile so the last lane drains completely. It sits between the tile buffer and one Systolic_Data_Setup instance, driving that instance's SYNC_RST, EN and Inputs.

## Interface
- DATA_WIDTH, 8, element width in bits.
- SA_LENGTH, 5, systolic array dimension: lanes per row and rows per tile (≥2).
- ADDR_WIDTH, 8, buffer row-address width.
- TILE_WIDTH, 8, width of the tile-count field.

- CLK  in  1  clock; all logic on the rising edge.
- ASYNC_RST  in  1  asynchronous, active-low reset.
- START  in  1  job request; sampled only in IDLE.
- BASE_ADDR  in  ADDR_WIDTH  first buffer row of the job; captured on START.
- NUM_TILES  in  TILE_WIDTH  number of SA_LENGTH-row tiles; captured on START.
- STALL  in  1  downstream back-pressure; freezes FEED/DRAIN.
- RD_EN  out  1  buffer read strobe.
- RD_ADDR  out  ADDR_WIDTH  buffer row address.
- RD_DATA  in  SA_LENGTH*DATA_WIDTH  row data, valid 1 cycle after RD_EN; buffer holds its output while RD_EN=0.
- SETUP_SYNC_RST  out  1  to skew stage SYNC_RST.
- SETUP_EN  out  1  to skew stage EN.
- SETUP_INPUTS  out  SA_LENGTH*DATA_WIDTH  to skew stage Inputs; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- BUSY  out  1  high from the cycle after START acceptance until DONE.
- DONE  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: START=1 captures BASE_ADDR, NUM_TILES, zeroes row/tile counters; NUM_TILES=0 → DONE, else → CLEAR. START outside IDLE is ignored.
- CLEAR: one cycle, SETUP_SYNC_RST=1, SETUP_EN=0; → FEED. Not affected by STALL.
- FEED: SA_LENGTH unstalled cycles; each cycle RD_EN=1, RD_ADDR=BASE_ADDR+tile*SA_LENGTH+row (modulo 2^ADDR_WIDTH, wrap silently), row increments; after row SA_LENGTH-1 → DRAIN.
- data_valid register = RD_EN of previous unstalled cycle; held while STALL=1.
- SETUP_INPUTS = RD_DATA when data_valid=1, else all zeros.
- DRAIN: SA_LENGTH unstalled cycles; RD_EN=0; first cycle still presents the last row (data_valid=1), remaining SA_LENGTH-1 cycles present zeros. At end: tile+1<NUM_TILES → tile++, → FEED (no CLEAR); else → DONE.
- SETUP_EN = (data_valid | state==DRAIN) & ~STALL.
- STALL=1 in FEED/DRAIN: RD_EN=0, SETUP_EN=0, counters and state frozen, SETUP_INPUTS held; resumes exactly where it stopped. STALL has no effect in IDLE/CLEAR/DONE.
- DONE: DONE=1 one cycle, BUSY=0 → IDLE. START in DONE ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-job aborts immediately; no DONE issued; first START after release begins a fresh job with CLEAR.
- Cycle n = n-th cycle after the edge sampling START. Unstalled: cycle 1 CLEAR; cycles 2..SA_LENGTH+1 FEED of tile 0; each tile occupies 2*SA_LENGTH cycles; DONE in cycle 2+2*SA_LENGTH*NUM_TILES. NUM_TILES=0: DONE in cycle 1, no CLEAR, no reads.
- Per tile SETUP_EN is high 2*SA_LENGTH-1 consecutive cycles starting at FEED cycle 2; low in FEED cycle 1 of every tile.
- Each STALL cycle in FEED/DRAIN adds exactly one cycle to DONE latency.

## Test plan
- Reset: hold ASYNC_RST=0 with random inputs -> all outputs 0; release, no START -> outputs stay 0.
- Single tile, SA_LENGTH=5, BASE_ADDR=0x10, NUM_TILES=1 -> SETUP_SYNC_RST in cycle 1, RD_ADDR 0x10..0x14 cycles 2-6, SETUP_EN cycles 3-11 with rows then 4 zero rows, DONE cycle 12, skew stage outputs match expected diagonal.
- Two tiles, BASE_ADDR=0xFC -> addresses 0xFC,0xFD,0xFE,0xFF,0x00 then 0x01..0x05; SETUP_EN low in cycle 12 only; DONE cycle 22.
- STALL for 3 cycles at FEED row 2 and 2 cycles mid-DRAIN -> no RD_EN/SETUP_EN during stall, SETUP_INPUTS held, identical data sequence, DONE cycle 17.
- NUM_TILES=0 -> DONE in cycle 1, no RD_EN, no SETUP_SYNC_RST; START pulses while BUSY -> ignored.
- ASYNC_RST asserted in DRAIN of tile 0 -> outputs 0 at once, no DONE; new START after release -> full CLEAR/FEED sequence from captured new BASE_ADDR.

Source files
------------

// File: rtl/systolic_feed_controller.sv
// Feeds SA_LENGTH-row tiles from a row-organised buffer into one systolic data-setup
// skew stage: clear before the job, read rows, then flush zeros so the last lane drains.
module systolic_feed_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int SA_LENGTH  = 5,
  parameter int ADDR_WIDTH = 8,
  parameter int TILE_WIDTH = 8
) (
  input  logic                            CLK,
  input  logic                            ASYNC_RST,
  input  logic                            START,
  input  logic [ADDR_WIDTH-1:0]           BASE_ADDR,
  input  logic [TILE_WIDTH-1:0]           NUM_TILES,
  input  logic                            STALL,
  output logic                            RD_EN,
  output logic [ADDR_WIDTH-1:0]           RD_ADDR,
  input  logic [SA_LENGTH*DATA_WIDTH-1:0] RD_DATA,
  output logic                            SETUP_SYNC_RST,
  output logic                            SETUP_EN,
  output logic [SA_LENGTH*DATA_WIDTH-1:0] SETUP_INPUTS,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [2:0]                      DBG_STATE
);

  localparam int RW = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(SA_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [TILE_WIDTH-1:0] tile_q, tile_d;
  logic [TILE_WIDTH-1:0] num_q, num_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  dv_q, dv_d;

  logic                  rd_en;
  logic                  frozen;
  logic [TILE_WIDTH:0]   tile_nxt;
  logic                  more_tiles;

  // Tile rows are contiguous in the buffer, so one running address covers every tile.
  assign tile_nxt   = {1'b0, tile_q} + (TILE_WIDTH+1)'(1);
  assign more_tiles = tile_nxt < {1'b0, num_q};
  assign frozen     = STALL && ((state_q == S_FEED) || (state_q == S_DRAIN));

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    tile_d         = tile_q;
    num_d          = num_q;
    addr_d         = addr_q;
    rd_en          = 1'b0;
    SETUP_SYNC_RST = 1'b0;
    DONE           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = BASE_ADDR;
          num_d   = NUM_TILES;
          row_d   = '0;
          tile_d  = '0;
          state_d = (NUM_TILES == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        SETUP_SYNC_RST = 1'b1;
        state_d        = S_FEED;
      end
      S_FEED: begin
        if (!STALL) begin
          rd_en  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = S_DRAIN;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!STALL) begin
          if (row_q == LAST_ROW) begin
            row_d = '0;
            if (more_tiles) begin
              tile_d  = tile_nxt[TILE_WIDTH-1:0];
              state_d = S_FEED;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // data_valid tracks the read strobe of the previous unstalled cycle.
    dv_d = frozen ? dv_q : rd_en;
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      tile_q  <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      dv_q    <= dv_d;
    end
  end

  assign RD_EN        = rd_en;
  assign RD_ADDR      = rd_en ? addr_q : '0;
  assign SETUP_EN     = (dv_q || (state_q == S_DRAIN)) && !STALL;
  assign SETUP_INPUTS = dv_q ? RD_DATA : '0;
  assign BUSY         = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
  assign DBG_STATE    = state_q;

endmodule
